// File: rtl/guess_entry_pkg.sv
// Shared constants and types for the guess entry block: digit codes, FSM states, buffer depth.
package guess_entry_pkg;

  localparam int unsigned DIGIT_W            = 3;
  localparam int unsigned MAX_DIGITS_DEFAULT = 5;

  localparam logic [DIGIT_W-1:0] DIGIT_NONE = DIGIT_W'(0);
  localparam logic [DIGIT_W-1:0] DIGIT_1    = DIGIT_W'(1);
  localparam logic [DIGIT_W-1:0] DIGIT_2    = DIGIT_W'(2);
  localparam logic [DIGIT_W-1:0] DIGIT_3    = DIGIT_W'(3);
  localparam logic [DIGIT_W-1:0] DIGIT_4    = DIGIT_W'(4);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ENTRY,
    ST_FULL,
    ST_OFFER
  } state_t;

endpackage

// File: rtl/guess_entry_button_debounce.sv
// One raw button: 2-flop synchronizer, counting debouncer, registered press pulse on debounced rise.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_rise
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_rise;
  logic [CW-1:0] r_cnt;

  // Level flips after DEBOUNCE_CYCLES consecutive differing samples; a matching sample restarts the count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      if (r_sync2 != r_level) begin
        if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          r_level <= r_sync2;
          r_rise  <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= CW'(r_cnt + CW'(1));
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/guess_entry.sv
// Collects debounced digit presses into a packed guess buffer and offers it on enter via valid/ready.
module guess_entry
  import guess_entry_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned MAX_DIGITS      = MAX_DIGITS_DEFAULT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          I1,
  input  logic                          I2,
  input  logic                          I3,
  input  logic                          I4,
  input  logic                          enter,
  output logic [DIGIT_W*MAX_DIGITS-1:0] guess,
  output logic [2:0]                    count,
  output logic                          guess_valid,
  input  logic                          guess_ready,
  output logic                          overflow,
  output logic                          busy
);

  localparam int unsigned GW = DIGIT_W * MAX_DIGITS;

  logic [4:0]         w_raw;
  logic [4:0]         w_ev;
  logic [DIGIT_W-1:0] w_digit;
  logic               w_digit_hit;
  logic               w_enter;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [GW-1:0]      r_guess;
  logic [GW-1:0]      w_guess_nxt;
  logic [2:0]         r_count;
  logic [2:0]         w_count_nxt;
  logic               r_ovf;
  logic               w_ovf_nxt;
  logic               r_valid;
  logic               r_busy;
  int unsigned        w_shift;

  assign w_raw = {enter, I4, I3, I2, I1};

  for (genvar gi = 0; gi < 5; gi++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
      .clk   (clk),
      .reset (reset),
      .i_raw (w_raw[gi]),
      .o_rise(w_ev[gi])
    );
  end

  // Simultaneous digit presses resolve to the lowest-numbered button.
  always_comb begin
    w_digit = DIGIT_NONE;
    if (w_ev[0])      w_digit = DIGIT_1;
    else if (w_ev[1]) w_digit = DIGIT_2;
    else if (w_ev[2]) w_digit = DIGIT_3;
    else if (w_ev[3]) w_digit = DIGIT_4;
  end

  assign w_digit_hit = (w_digit != DIGIT_NONE);
  assign w_enter     = w_ev[4];

  always_comb begin
    w_state_nxt = r_state;
    w_guess_nxt = r_guess;
    w_count_nxt = r_count;
    w_ovf_nxt   = 1'b0;
    w_shift     = 0;
    case (r_state)
      ST_EMPTY, ST_ENTRY: begin
        // Digit lands before enter is evaluated so a same-cycle enter includes it.
        if (w_digit_hit) begin
          w_shift     = DIGIT_W * (MAX_DIGITS - 1 - 32'(r_count));
          w_guess_nxt = r_guess | (GW'(w_digit) << w_shift);
          w_count_nxt = r_count + 3'd1;
        end
        if (w_enter && (w_count_nxt != 3'd0))      w_state_nxt = ST_OFFER;
        else if (w_count_nxt == 3'(MAX_DIGITS))    w_state_nxt = ST_FULL;
        else if (w_count_nxt != 3'd0)              w_state_nxt = ST_ENTRY;
        else                                       w_state_nxt = ST_EMPTY;
      end
      ST_FULL: begin
        w_ovf_nxt = w_digit_hit;
        if (w_enter) w_state_nxt = ST_OFFER;
      end
      ST_OFFER: begin
        if (guess_ready) begin
          w_state_nxt = ST_EMPTY;
          w_guess_nxt = '0;
          w_count_nxt = 3'd0;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
        w_guess_nxt = '0;
        w_count_nxt = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_EMPTY;
      r_guess <= '0;
      r_count <= 3'd0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_guess <= w_guess_nxt;
      r_count <= w_count_nxt;
      r_ovf   <= w_ovf_nxt;
      r_valid <= (w_state_nxt == ST_OFFER);
      r_busy  <= (w_state_nxt != ST_EMPTY);
    end
  end

  assign guess       = r_guess;
  assign count       = r_count;
  assign guess_valid = r_valid;
  assign overflow    = r_ovf;
  assign busy        = r_busy;

endmodule

// File: doc/guess_entry.md
GUESS_ENTRY -- requirements
Module: guess_entry

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized samples required before a button level is accepted.
REQ-002 Parameter MAX_DIGITS, default 5: guess buffer depth in digits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 I1, I2, I3, I4  input  1 each  raw asynchronous digit buttons; a press of In means digit value n.
REQ-006 enter  input  1  raw asynchronous commit button.
REQ-007 guess  output  3*MAX_DIGITS  packed digits, first-entered digit in the most significant 3-bit field, unused fields 0.
REQ-008 count  output  3  number of valid digits in guess, 0..MAX_DIGITS.
REQ-009 guess_valid  output  1  guess/count offered to the game stage.
REQ-010 guess_ready  input  1  game stage accepts the offer.
REQ-011 overflow  output  1  one-cycle pulse when a digit is discarded because the buffer is full.
REQ-012 busy  output  1  high while any digit is buffered or an offer is pending.

Function
REQ-013 Each of the 5 raw inputs passes through a 2-flop synchronizer and then a debouncer.
REQ-014 Debouncer: its level changes only after DEBOUNCE_CYCLES consecutive synchronized samples that differ from the current level; any opposite sample restarts the count.
REQ-015 Press event: one-cycle pulse on the debounced rising edge; raw high held from edge k gives the event at edge k+2+DEBOUNCE_CYCLES.
REQ-016 Releases generate no event; a held button generates exactly one event.
REQ-017 Digit encoding: 3'd1..3'd4 for I1..I4; 3'd0 means empty.
REQ-018 FSM states: EMPTY (count=0), ENTRY (0<count<MAX_DIGITS), FULL (count=MAX_DIGITS), OFFER (guess_valid=1).
REQ-019 Digit event in EMPTY/ENTRY: digit written to field index count, count+1; ENTRY->FULL when count reaches MAX_DIGITS.
REQ-020 Digit event in FULL: digit discarded, overflow pulses for the same cycle, state unchanged.
REQ-021 Simultaneous digit events: priority I1>I2>I3>I4; only one digit accepted, others dropped silently.
REQ-022 Enter event in ENTRY or FULL: -> OFFER next cycle; guess/count frozen.
REQ-023 Enter event in EMPTY: ignored, no offer.
REQ-024 Digit and enter events in the same cycle in EMPTY/ENTRY: digit appended first, then the offer includes it.
REQ-025 OFFER: guess_valid held high, guess/count stable until a cycle with guess_ready=1.
REQ-026 On the accepting cycle: next cycle guess=0, count=0, guess_valid=0, state EMPTY.
REQ-027 All digit and enter events arriving in OFFER are discarded; no overflow pulse.
REQ-028 busy = (state != EMPTY).

Reset
REQ-029 With reset low at a clock edge: state EMPTY, guess=0, count=0, guess_valid=0, overflow=0, busy=0.
REQ-030 Synchronizer flops, debounced levels and debounce counters clear to 0 (released).
REQ-031 Reset mid-entry or during OFFER discards the buffer and any pending offer; nothing is delivered.
REQ-032 A button held through reset deassertion produces one press event after the normal REQ-015 latency.

Structure
REQ-033 A shared package holds: digit code constants DIGIT_NONE/DIGIT_1..DIGIT_4, DIGIT_W=3, state enum typedef, and the MAX_DIGITS default.
REQ-034 One sub-module button_debounce (synchronizer + debouncer + rise pulse, parameter DEBOUNCE_CYCLES), instantiated five times.

Verification
REQ-035 Press I1,I2,I3,I4 with gaps, then enter, guess_ready=1 -> guess=15'b001_010_011_100_000, count=4, guess_valid high exactly one cycle.
REQ-036 Press 4,2,4,1,3,1 (six digits) then enter -> overflow pulses once on the sixth press; guess=100_010_100_001_011, count=5.
REQ-037 Glitch: I2 high for DEBOUNCE_CYCLES-1 cycles, then low -> no digit accepted; count stays 0.
REQ-038 Enter with empty buffer -> guess_valid stays 0, busy stays 0.
REQ-039 Enter with guess_ready=0 for 10 cycles, press I3 meanwhile -> guess_valid and guess held; I3 dropped; on guess_ready=1 the buffer clears.
REQ-040 Enter digits 1,4, assert reset low one cycle -> count=0, busy=0; a later enter produces no offer.
